// File: rtl/uvmt_cv32e40x_pma_lookup_sequencer.sv
// Drives one or two PMA model lookups per core request and merges the
// per-beat status into a single handshaked response with coverage counters.
module uvmt_cv32e40x_pma_lookup_sequencer #(
    parameter bit          IS_INSTR_SIDE = 1'b0,
    parameter int unsigned IDX_W         = 5,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_load_i,
    input  logic             req_dbg_i,
    input  logic             req_pushpop_i,
    output logic             pma_valid_o,
    output logic [31:0]      pma_addr_o,
    output logic             pma_misaligned_o,
    output logic             pma_load_o,
    output logic             pma_dbg_o,
    output logic             pma_pushpop_o,
    input  logic             pma_allow_i,
    input  logic             pma_main_i,
    input  logic             pma_bufferable_i,
    input  logic [IDX_W-1:0] pma_match_idx_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_allow_o,
    output logic             rsp_main_o,
    output logic             rsp_bufferable_o,
    output logic             rsp_split_o,
    output logic             rsp_fault_beat_o,
    output logic [IDX_W-1:0] rsp_idx0_o,
    output logic [IDX_W-1:0] rsp_idx1_o,
    output logic [CNT_W-1:0] lookup_cnt_o,
    output logic [CNT_W-1:0] fault_cnt_o
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q;
    logic [1:0]       size_q;
    logic             load_q, dbg_q, pushpop_q;
    logic [2:0]       bytes, end_off;
    logic             split, misaligned;
    logic             allow_q, main_q, buf_q, split_q, fault_beat_q;
    logic [IDX_W-1:0] idx0_q, idx1_q;
    logic [CNT_W-1:0] lookup_cnt_q, fault_cnt_q;

    // Size 3 is folded into the word case for both length and alignment.
    always_comb begin
        case (size_q)
            2'd0:    bytes = 3'd1;
            2'd1:    bytes = 3'd2;
            default: bytes = 3'd4;
        endcase
        end_off    = {1'b0, addr_q[1:0]} + bytes;
        split      = end_off > 3'd4;
        misaligned = ((size_q == 2'd1) && addr_q[0]) ||
                     (size_q[1] && (addr_q[1:0] != 2'b00));
    end

    always_comb begin
        state_d          = state_q;
        req_ready_o      = 1'b0;
        pma_valid_o      = 1'b0;
        pma_addr_o       = '0;
        pma_misaligned_o = 1'b0;
        pma_load_o       = 1'b0;
        pma_dbg_o        = 1'b0;
        pma_pushpop_o    = 1'b0;
        rsp_valid_o      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = BEAT0;
            end
            BEAT0, BEAT1: begin
                pma_valid_o      = 1'b1;
                pma_load_o       = load_q & ~IS_INSTR_SIDE;
                pma_dbg_o        = dbg_q;
                pma_pushpop_o    = pushpop_q & ~IS_INSTR_SIDE;
                if (state_q == BEAT0) begin
                    pma_addr_o       = addr_q;
                    pma_misaligned_o = misaligned;
                    state_d          = (split && pma_allow_i) ? BEAT1 : RESP;
                end else begin
                    pma_addr_o       = {addr_q[31:2] + 30'd1, 2'b00};
                    pma_misaligned_o = 1'b1;
                    state_d          = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            load_q       <= 1'b0;
            dbg_q        <= 1'b0;
            pushpop_q    <= 1'b0;
            allow_q      <= 1'b0;
            main_q       <= 1'b0;
            buf_q        <= 1'b0;
            split_q      <= 1'b0;
            fault_beat_q <= 1'b0;
            idx0_q       <= '0;
            idx1_q       <= '0;
            lookup_cnt_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid_i) begin
                addr_q    <= req_addr_i;
                size_q    <= req_size_i;
                load_q    <= req_load_i;
                dbg_q     <= req_dbg_i;
                pushpop_q <= req_pushpop_i;
            end
            if (state_q == BEAT0) begin
                allow_q      <= pma_allow_i;
                main_q       <= pma_main_i;
                buf_q        <= pma_bufferable_i;
                split_q      <= split;
                fault_beat_q <= 1'b0;
                idx0_q       <= pma_match_idx_i;
                idx1_q       <= '0;
            end
            // Beat 1 only runs after an allowed beat 0, so a deny here is the first fault.
            if (state_q == BEAT1) begin
                allow_q      <= allow_q & pma_allow_i;
                main_q       <= main_q & pma_main_i;
                buf_q        <= buf_q & pma_bufferable_i;
                fault_beat_q <= ~pma_allow_i;
                idx1_q       <= pma_match_idx_i;
            end
            if ((state_q == BEAT0 || state_q == BEAT1) && lookup_cnt_q != '1)
                lookup_cnt_q <= lookup_cnt_q + CNT_W'(1);
            if (state_q == RESP && rsp_ready_i && !allow_q && fault_cnt_q != '1)
                fault_cnt_q <= fault_cnt_q + CNT_W'(1);
        end
    end

    assign rsp_allow_o      = allow_q;
    assign rsp_main_o       = main_q;
    assign rsp_bufferable_o = buf_q;
    assign rsp_split_o      = split_q;
    assign rsp_fault_beat_o = fault_beat_q;
    assign rsp_idx0_o       = idx0_q;
    assign rsp_idx1_o       = idx1_q;
    assign lookup_cnt_o     = lookup_cnt_q;
    assign fault_cnt_o      = fault_cnt_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_pma_lookup_sequencer.sv
// Directed bench: data-side sequencer plus an instruction-side, 2-bit-counter
// instance sharing the same stimulus and PMA model responses.
module tb_uvmt_cv32e40x_pma_lookup_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_load, req_dbg, req_pushpop, rsp_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        pma_allow, pma_main, pma_buf;
    logic [4:0]  pma_idx;

    logic        req_ready, pma_valid, pma_mis, pma_load, pma_dbg, pma_pp;
    logic [31:0] pma_addr;
    logic        rsp_valid, rsp_allow, rsp_main, rsp_buf, rsp_split, rsp_fb;
    logic [4:0]  rsp_idx0, rsp_idx1;
    logic [15:0] lookup_cnt, fault_cnt;

    logic        b_req_ready, b_pma_valid, b_pma_mis, b_pma_load, b_pma_dbg, b_pma_pp;
    logic [31:0] b_pma_addr;
    logic        b_rsp_valid, b_rsp_allow, b_rsp_main, b_rsp_buf, b_rsp_split, b_rsp_fb;
    logic [4:0]  b_rsp_idx0, b_rsp_idx1;
    logic [1:0]  b_lookup_cnt, b_fault_cnt;

    // Model: beat 0 values when the looked-up address is the request address.
    logic [31:0] cur_addr;
    logic        m_allow0, m_main0, m_buf0, m_allow1, m_main1, m_buf1;
    logic [4:0]  m_idx0, m_idx1;
    logic        sel;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        sel       = (pma_addr != cur_addr);
        pma_allow = sel ? m_allow1 : m_allow0;
        pma_main  = sel ? m_main1  : m_main0;
        pma_buf   = sel ? m_buf1   : m_buf0;
        pma_idx   = sel ? m_idx1   : m_idx0;
    end

    uvmt_cv32e40x_pma_lookup_sequencer #(.IS_INSTR_SIDE(1'b0), .IDX_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_size_i(req_size), .req_load_i(req_load), .req_dbg_i(req_dbg),
        .req_pushpop_i(req_pushpop),
        .pma_valid_o(pma_valid), .pma_addr_o(pma_addr), .pma_misaligned_o(pma_mis),
        .pma_load_o(pma_load), .pma_dbg_o(pma_dbg), .pma_pushpop_o(pma_pp),
        .pma_allow_i(pma_allow), .pma_main_i(pma_main), .pma_bufferable_i(pma_buf),
        .pma_match_idx_i(pma_idx),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
        .rsp_main_o(rsp_main), .rsp_bufferable_o(rsp_buf), .rsp_split_o(rsp_split),
        .rsp_fault_beat_o(rsp_fb), .rsp_idx0_o(rsp_idx0), .rsp_idx1_o(rsp_idx1),
        .lookup_cnt_o(lookup_cnt), .fault_cnt_o(fault_cnt)
    );

    uvmt_cv32e40x_pma_lookup_sequencer #(.IS_INSTR_SIDE(1'b1), .IDX_W(5), .CNT_W(2)) dut_i (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(b_req_ready), .req_addr_i(req_addr),
        .req_size_i(req_size), .req_load_i(req_load), .req_dbg_i(req_dbg),
        .req_pushpop_i(req_pushpop),
        .pma_valid_o(b_pma_valid), .pma_addr_o(b_pma_addr), .pma_misaligned_o(b_pma_mis),
        .pma_load_o(b_pma_load), .pma_dbg_o(b_pma_dbg), .pma_pushpop_o(b_pma_pp),
        .pma_allow_i(pma_allow), .pma_main_i(pma_main), .pma_bufferable_i(pma_buf),
        .pma_match_idx_i(pma_idx),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(b_rsp_allow),
        .rsp_main_o(b_rsp_main), .rsp_bufferable_o(b_rsp_buf), .rsp_split_o(b_rsp_split),
        .rsp_fault_beat_o(b_rsp_fb), .rsp_idx0_o(b_rsp_idx0), .rsp_idx1_o(b_rsp_idx1),
        .lookup_cnt_o(b_lookup_cnt), .fault_cnt_o(b_fault_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_model(input logic a0, m0, b0, input logic [4:0] i0,
                             input logic a1, m1, b1, input logic [4:0] i1);
        m_allow0 = a0; m_main0 = m0; m_buf0 = b0; m_idx0 = i0;
        m_allow1 = a1; m_main1 = m1; m_buf1 = b1; m_idx1 = i1;
    endtask

    // Presents a request in IDLE and leaves the bench in the first BEAT0 cycle.
    task automatic issue(input logic [31:0] a, input logic [1:0] s,
                         input logic ld, input logic dbg, input logic pp);
        req_addr = a; req_size = s; req_load = ld; req_dbg = dbg; req_pushpop = pp;
        cur_addr = a;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0;
        req_load = 1'b0; req_dbg = 1'b0; req_pushpop = 1'b0; rsp_ready = 1'b1;
        cur_addr = '0;
        set_model(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_pma_valid", pma_valid, 0);
        chk("rst_lookup", lookup_cnt, 0);
        #10 rst_n = 1'b1;
        tick();

        // Aligned word load: single beat, response two cycles after accept.
        set_model(1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0);
        issue(32'h0000_1000, 2'd2, 1'b1, 1'b0, 1'b0);
        chk("w_pma_valid", pma_valid, 1);
        chk("w_pma_addr", pma_addr, 32'h0000_1000);
        chk("w_pma_mis", pma_mis, 0);
        chk("w_pma_load", pma_load, 1);
        chk("w_i_pma_load", b_pma_load, 0);
        chk("w_rsp_early", rsp_valid, 0);
        tick();
        chk("w_rsp_valid", rsp_valid, 1);
        chk("w_rsp_allow", rsp_allow, 1);
        chk("w_rsp_main", rsp_main, 1);
        chk("w_rsp_buf", rsp_buf, 0);
        chk("w_rsp_split", rsp_split, 0);
        chk("w_rsp_idx0", rsp_idx0, 2);
        chk("w_lookup", lookup_cnt, 1);
        chk("w_pma_idle", pma_valid, 0);
        chk("w_req_ready_resp", req_ready, 0);
        tick();
        chk("w_done", rsp_valid, 0);

        // Misaligned word store crossing into the next word.
        set_model(1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd3);
        issue(32'h0000_1002, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("s_b0_addr", pma_addr, 32'h0000_1002);
        chk("s_b0_mis", pma_mis, 1);
        chk("s_b0_load", pma_load, 0);
        tick();
        chk("s_b1_valid", pma_valid, 1);
        chk("s_b1_addr", pma_addr, 32'h0000_1004);
        chk("s_b1_mis", pma_mis, 1);
        chk("s_rsp_n2", rsp_valid, 0);
        tick();
        chk("s_rsp_valid", rsp_valid, 1);
        chk("s_rsp_split", rsp_split, 1);
        chk("s_rsp_allow", rsp_allow, 1);
        chk("s_rsp_main", rsp_main, 0);
        chk("s_rsp_buf", rsp_buf, 1);
        chk("s_rsp_idx0", rsp_idx0, 1);
        chk("s_rsp_idx1", rsp_idx1, 3);
        chk("s_rsp_fb", rsp_fb, 0);
        chk("s_lookup", lookup_cnt, 3);
        tick();
        chk("s_fault_cnt", fault_cnt, 0);

        // Split halfword denied on beat 0: beat 1 skipped.
        set_model(1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd6);
        issue(32'h0000_2003, 2'd1, 1'b1, 1'b1, 1'b1);
        chk("h_b0_mis", pma_mis, 1);
        chk("h_b0_dbg", pma_dbg, 1);
        chk("h_b0_pp", pma_pp, 1);
        chk("h_i_b0_pp", b_pma_pp, 0);
        chk("h_i_b0_dbg", b_pma_dbg, 1);
        tick();
        chk("h_rsp_valid", rsp_valid, 1);
        chk("h_rsp_allow", rsp_allow, 0);
        chk("h_rsp_fb", rsp_fb, 0);
        chk("h_rsp_split", rsp_split, 1);
        chk("h_rsp_idx0", rsp_idx0, 7);
        chk("h_rsp_idx1", rsp_idx1, 0);
        chk("h_lookup", lookup_cnt, 4);
        tick();
        chk("h_fault_cnt", fault_cnt, 1);

        // Top-of-memory wrap, beat 1 denied, response held off for 5 cycles.
        set_model(1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 5'd9);
        issue(32'hFFFF_FFFE, 2'd2, 1'b1, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        chk("x_b0_addr", pma_addr, 32'hFFFF_FFFE);
        tick();
        chk("x_b1_addr", pma_addr, 32'h0000_0000);
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h0000_3000;
        for (int i = 0; i < 5; i++) begin
            chk("x_hold_valid", rsp_valid, 1);
            chk("x_hold_fb", rsp_fb, 1);
            chk("x_hold_allow", rsp_allow, 0);
            chk("x_hold_idx1", rsp_idx1, 9);
            chk("x_hold_req_ready", req_ready, 0);
            tick();
        end
        chk("x_hold_pma_valid", pma_valid, 0);
        chk("x_fault_pending", fault_cnt, 1);
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        tick();
        chk("x_idle_rsp", rsp_valid, 0);
        chk("x_idle_ready", req_ready, 1);
        chk("x_fault_cnt", fault_cnt, 2);
        chk("x_lookup", lookup_cnt, 6);
        tick();
        chk("x_not_taken", pma_valid, 0);

        // Reset asserted while beat 1 is on the model interface.
        set_model(1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd2);
        issue(32'h0000_1002, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk("r_in_beat1", pma_addr, 32'h0000_1004);
        rst_n = 1'b0;
        #1;
        chk("r_pma_valid", pma_valid, 0);
        chk("r_pma_addr", pma_addr, 0);
        chk("r_req_ready", req_ready, 1);
        chk("r_rsp_valid", rsp_valid, 0);
        chk("r_rsp_split", rsp_split, 0);
        chk("r_lookup", lookup_cnt, 0);
        chk("r_fault", fault_cnt, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r_no_rsp", rsp_valid, 0);
        end

        // Five single-beat lookups: 16-bit counter counts, 2-bit counter saturates.
        set_model(1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5);
        for (int k = 1; k <= 5; k++) begin
            issue(32'h0000_4000, 2'd2, 1'b0, 1'b0, 1'b0);
            tick();
            chk("c_rsp_valid", rsp_valid, 1);
            tick();
            chk("c_lookup", lookup_cnt, k);
            chk("c_sat_lookup", b_lookup_cnt, (k > 3) ? 3 : k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
